kbd_matrix_scanner: RTL and testbench
=====================================

Name: kbd_matrix_scanner

Overview:
Parametrised successor to the fixed 9x10 keyboard scanner. It drives the columns of a ROWS x COLS key matrix one-hot and samples the rows through a synchroniser. Each key is debounced over several full scans. Confirmed press/release changes are pushed as events into a small FIFO read over a valid/ready handshake. The block sits between the kbd_row/kbd_col pads and the CSR/interrupt layer, in a single clock domain; scan pacing comes from internal counters rather than lpclk.

Parameters:
ROWS, 9, number of row inputs (>=1)
COLS, 10, number of column drive outputs (>=1)
SETTLE_CYCLES, 4, clk cycles a column is driven before sampling (>=3, covers the 2-FF synchroniser)
DEBOUNCE_SCANS, 2, consecutive scans a new level must persist before it is accepted (>=1)
SCAN_GAP, 16, idle clk cycles between full scans (>=0)
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  scan enable; sampled only at scan boundaries
kbd_col  out  COLS  one-hot active-high column drive; all zero when idle
kbd_row  in  ROWS  raw row inputs, asynchronous, active-high
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pop
evt_data  out  1+RW+CW  {pressed, row_idx[RW-1:0], col_idx[CW-1:0]}; RW=clog2(ROWS), CW=clog2(COLS)
keys_state  out  ROWS*COLS  debounced matrix, bit r*COLS+c
any_key  out  1  OR of keys_state
scan_done  out  1  one-cycle pulse at the end of each full scan
fifo_overflow  out  1  sticky; set when an event is dropped
clear_overflow  in  1  clears fifo_overflow (set has priority in the same cycle)
ghost  out  1  see Optional Feature

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values: kbd_col=0, evt_valid=0, keys_state=0, all debounce counters=0, scan_done=0, fifo_overflow=0, ghost=0, FSM=IDLE, col index=0, FIFO empty.
- Row input: kbd_row passes through a 2-FF synchroniser before any use.
- FSM states:
  - IDLE: kbd_col=0. Go to DRIVE(col 0) when enable=1.
  - DRIVE: kbd_col[c]=1 for SETTLE_CYCLES cycles.
  - SAMPLE: 1 cycle; latch the synchronised rows into sample[ROWS-1:0]. kbd_col stays driven.
  - EMIT: ROWS cycles, r=0..ROWS-1 ascending; kbd_col=0. Each cycle processes key (r,c):
    - sample==stable: cnt<=0.
    - sample!=stable and cnt+1==DEBOUNCE_SCANS: stable<=sample, cnt<=0, push {sample,r,c}.
    - otherwise: cnt<=cnt+1.
  - After EMIT: c<COLS-1 -> DRIVE(c+1); c==COLS-1 -> pulse scan_done, go to GAP.
  - GAP: SCAN_GAP cycles, then DRIVE(0) if enable=1, else IDLE.
- Scan period: COLS*(SETTLE_CYCLES+1+ROWS)+SCAN_GAP cycles. Defaults: 10*14+16=156.
- Debounce counter width: clog2(DEBOUNCE_SCANS+1). A mismatch that disappears for one scan restarts its count.
- enable deasserted mid-scan: the current scan completes. rst mid-scan: immediate return to the reset state, with all stable keys cleared and no release events emitted.
- FIFO push when full: event dropped, keys_state still updates, fifo_overflow<=1.
- FIFO push and pop in the same cycle: both succeed, including when full. Pop while empty is ignored.
- evt_data and evt_valid are registered FIFO outputs (first-word-fall-through) and hold stable while evt_valid=1 and evt_ready=0.
- keys_state and any_key update the cycle after the EMIT step that changes them.

Optional Feature:
KBD_GHOST_DETECT_EN
- Defined: at every scan_done, ghost<=1 if any two rows of keys_state share >=2 pressed columns (rectangle, so phantom keys are possible); else ghost<=0. The flag holds until the next scan_done.
- Not defined: ghost tied to 0 and no detection logic is generated.

Decomposition:
- Package kbd_pkg: FSM state enum (IDLE, DRIVE, SAMPLE, EMIT, GAP); evt_data field-width functions (RW, CW); clog2 helper; event struct typedef.
- One sub-module: kbd_evt_fifo, a synchronous FWFT FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty.

Test Plan:
- Defaults, no key, enable=1: kbd_col walks one-hot 0x001..0x200, each bit held 5 cycles; scan_done every 156 cycles; evt_valid stays 0.
- Row 3 wired to col[2] (row=col[2]<<3): after the 2nd scan_done, exactly one event {1,3,2}; keys_state bit 32 =1; any_key=1. Remove the key: release event {0,3,2} after 2 more scans.
- Bounce: key present in scan 1, absent in scan 2, present in scans 3–4 -> the single press event comes after scan 4 only.
- Keys (3,2) and (3,4) together: both events emitted, col 2 before col 4. Keys (1,5),(6,5) in the same column: both events, row 1 first.
- evt_ready=0 with 10 presses across distinct keys: 8 events retained in order; fifo_overflow=1; clear_overflow clears it; all 10 keys are set in keys_state.
- With KBD_GHOST_DETECT_EN: keys (1,2),(1,4),(3,2) held -> ghost=0. Add (3,4) -> ghost=1 at the following scan_done. rst mid-scan -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and width helpers for the keyboard matrix scanner.
package kbd_pkg;

   // Scanner FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_EMIT,
      ST_GAP
   } kbd_state_e;

   // Ceiling log2; clog2(1) = 0
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      logic [32:0] p;
      w = 0;
      p = 33'd1;
      while (p < 33'(n)) begin
         p = p << 1;
         w++;
      end
      return w;
   endfunction

   // Field width for an index over n items, at least one bit
   function automatic int unsigned fld_w(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

   // Event word width: {pressed, row_idx, col_idx}
   function automatic int unsigned evt_w(input int unsigned rows, input int unsigned cols);
      return 1 + fld_w(rows) + fld_w(cols);
   endfunction

   localparam int unsigned KBD_DEF_ROWS = 9;
   localparam int unsigned KBD_DEF_COLS = 10;
   localparam int unsigned KBD_DEF_RW   = fld_w(KBD_DEF_ROWS);
   localparam int unsigned KBD_DEF_CW   = fld_w(KBD_DEF_COLS);

   // Event payload for the default 9x10 geometry
   typedef struct packed {
      logic                  pressed;
      logic [KBD_DEF_RW-1:0] row;
      logic [KBD_DEF_CW-1:0] col;
   } kbd_evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: synchronous first-word-fall-through FIFO with a registered head.
module kbd_evt_fifo
   import kbd_pkg::*;
#(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = fld_w(DEPTH);
   localparam int unsigned NW = clog2(DEPTH + 1);
   localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [NW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_head;
   logic             r_valid;
   logic             r_full;
   logic             r_empty;

   logic             w_do_pop;
   logic             w_do_push;
   logic [NW-1:0]    w_cnt_nxt;
   logic [AW-1:0]    w_rd_inc;
   logic [WIDTH-1:0] w_head_nxt;

   // Accept logic; a push into a full FIFO succeeds only alongside a pop
   always_comb begin
      w_do_pop   = i_pop && (r_cnt != '0);
      w_do_push  = i_push && ((r_cnt != DEPTH_C) || w_do_pop);
      w_cnt_nxt  = r_cnt + NW'(w_do_push) - NW'(w_do_pop);
      w_rd_inc   = r_rd + AW'(1);
      w_head_nxt = r_head;
      if (r_cnt == '0) begin
         if (w_do_push) w_head_nxt = i_data;
      end else if (w_do_pop) begin
         if (r_cnt == NW'(1)) w_head_nxt = i_data;
         else                 w_head_nxt = r_mem[w_rd_inc];
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   // Pointers, occupancy and registered head/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_head  <= '0;
         r_valid <= 1'b0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= w_rd_inc;
         r_cnt   <= w_cnt_nxt;
         r_head  <= w_head_nxt;
         r_valid <= (w_cnt_nxt != '0);
         r_full  <= (w_cnt_nxt == DEPTH_C);
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_data  = r_head;
   assign o_valid = r_valid;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/kbd_matrix_scanner.sv
// kbd_matrix_scanner: one-hot column scan, per-key debounce, event FIFO.
// Optional ghost (rectangle) detection is built when KBD_GHOST_DETECT_EN is defined.
module kbd_matrix_scanner
   import kbd_pkg::*;
#(
   parameter int unsigned ROWS           = 9,
   parameter int unsigned COLS           = 10,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned DEBOUNCE_SCANS = 2,
   parameter int unsigned SCAN_GAP       = 16,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   output logic [COLS-1:0]               kbd_col,
   input  logic [ROWS-1:0]               kbd_row,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [evt_w(ROWS,COLS)-1:0]   evt_data,
   output logic [ROWS*COLS-1:0]          keys_state,
   output logic                          any_key,
   output logic                          scan_done,
   output logic                          fifo_overflow,
   input  logic                          clear_overflow,
   output logic                          ghost
);

   localparam int unsigned RW        = fld_w(ROWS);
   localparam int unsigned CW        = fld_w(COLS);
   localparam int unsigned EW        = evt_w(ROWS, COLS);
   localparam int unsigned NK        = ROWS * COLS;
   localparam int unsigned KW        = fld_w(NK);
   localparam int unsigned DCW       = clog2(DEBOUNCE_SCANS + 1);
   localparam int unsigned CNT_MAX_A = (SETTLE_CYCLES > ROWS) ? SETTLE_CYCLES : ROWS;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > SCAN_GAP) ? CNT_MAX_A : SCAN_GAP;
   localparam int unsigned CNT_W     = fld_w(CNT_MAX);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(SCAN_GAP - 1);
   localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);
   localparam logic [DCW-1:0]   DB_LAST     = DCW'(DEBOUNCE_SCANS - 1);

   typedef struct packed {
      logic          pressed;
      logic [RW-1:0] row;
      logic [CW-1:0] col;
   } evt_t;

   kbd_state_e       r_state;
   kbd_state_e       w_state_nxt;
   logic [CW-1:0]    r_col;
   logic [CW-1:0]    w_col_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_emit;
   logic             w_scan_end;

   logic [ROWS-1:0]  r_row_s1;
   logic [ROWS-1:0]  r_row_s2;
   logic [ROWS-1:0]  r_sample;
   logic [COLS-1:0]  r_kbd_col;
   logic             r_scan_done;
   logic             r_ovf;

   logic [NK-1:0]    r_stable;
   logic [NK-1:0]    w_stable_nxt;
   logic             r_any;
   logic [DCW-1:0]   r_dcnt [NK];

   logic [RW-1:0]    w_row;
   logic [KW-1:0]    w_key;
   logic             w_smp;
   logic             w_cur;
   logic [DCW-1:0]   w_cnt_cur;
   logic             w_accept;
   evt_t             w_evt;

   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_pop;

   // Two-flop synchroniser on the asynchronous row inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_s1 <= '0;
         r_row_s2 <= '0;
      end else begin
         r_row_s1 <= kbd_row;
         r_row_s2 <= r_row_s1;
      end
   end

   // Scan FSM state, column index and phase counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_col   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Scan FSM next-state; enable is only looked at between scans
   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_scan_end  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_DRIVE;
               w_col_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         end
         ST_DRIVE: begin
            if (r_cnt == SETTLE_LAST) begin
               w_state_nxt = ST_SAMPLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            w_state_nxt = ST_EMIT;
            w_cnt_nxt   = '0;
         end
         ST_EMIT: begin
            w_emit = 1'b1;
            if (r_cnt == ROW_LAST) begin
               w_cnt_nxt = '0;
               if (r_col == COL_LAST) begin
                  w_scan_end = 1'b1;
                  w_col_nxt  = '0;
                  if (SCAN_GAP == 0) w_state_nxt = enable ? ST_DRIVE : ST_IDLE;
                  else               w_state_nxt = ST_GAP;
               end else begin
                  w_col_nxt   = r_col + CW'(1);
                  w_state_nxt = ST_DRIVE;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = enable ? ST_DRIVE : ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Column drive follows the upcoming state so kbd_col tracks DRIVE/SAMPLE exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         r_kbd_col   <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_kbd_col   <= ((w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE))
                        ? (COLS'(1) << w_col_nxt) : '0;
         r_scan_done <= w_scan_end;
      end
   end

   // Capture the settled rows for the current column
   always_ff @(posedge clk) begin
      if (rst)                     r_sample <= '0;
      else if (r_state == ST_SAMPLE) r_sample <= r_row_s2;
   end

   // Per-key debounce decision for the key addressed in this EMIT cycle
   always_comb begin
      w_row        = RW'(r_cnt);
      w_key        = KW'(32'(w_row) * COLS + 32'(r_col));
      w_smp        = r_sample[w_row];
      w_cur        = r_stable[w_key];
      w_cnt_cur    = r_dcnt[w_key];
      w_accept     = w_emit && (w_smp != w_cur) && (w_cnt_cur == DB_LAST);
      w_stable_nxt = r_stable;
      if (w_accept) w_stable_nxt[w_key] = w_smp;
      w_evt.pressed = w_smp;
      w_evt.row     = w_row;
      w_evt.col     = r_col;
   end

   // Debounced matrix and counters; a vanished mismatch restarts its count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable <= '0;
         r_any    <= 1'b0;
         r_dcnt   <= '{default: '0};
      end else begin
         r_stable <= w_stable_nxt;
         r_any    <= |w_stable_nxt;
         if (w_emit) begin
            if ((w_smp == w_cur) || w_accept) r_dcnt[w_key] <= '0;
            else                              r_dcnt[w_key] <= w_cnt_cur + DCW'(1);
         end
      end
   end

   assign w_pop = evt_ready && !w_fifo_empty;

   kbd_evt_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_data  (w_evt),
      .i_pop   (w_pop),
      .o_data  (evt_data),
      .o_valid (evt_valid),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Sticky drop flag; a drop in the same cycle beats the clear
   always_ff @(posedge clk) begin
      if (rst)                                 r_ovf <= 1'b0;
      else if (w_accept && w_fifo_full && !w_pop) r_ovf <= 1'b1;
      else if (clear_overflow)                 r_ovf <= 1'b0;
   end

`ifdef KBD_GHOST_DETECT_EN
   logic            r_ghost;
   logic            w_ghost_c;
   logic [COLS-1:0] w_share;

   // Two rows sharing two or more pressed columns form a phantom-capable rectangle
   always_comb begin
      w_ghost_c = 1'b0;
      w_share   = '0;
      for (int unsigned a = 0; a < ROWS; a++) begin
         for (int unsigned b = a + 1; b < ROWS; b++) begin
            w_share = r_stable[a*COLS +: COLS] & r_stable[b*COLS +: COLS];
            if ((w_share & (w_share - COLS'(1))) != '0) w_ghost_c = 1'b1;
         end
      end
   end

   // Ghost flag is re-evaluated once per scan on the finished matrix
   always_ff @(posedge clk) begin
      if (rst)              r_ghost <= 1'b0;
      else if (r_scan_done) r_ghost <= w_ghost_c;
   end

   assign ghost = r_ghost;
`else
   assign ghost = 1'b0;
`endif

   assign kbd_col       = r_kbd_col;
   assign keys_state    = r_stable;
   assign any_key       = r_any;
   assign scan_done     = r_scan_done;
   assign fifo_overflow = r_ovf;

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
// Directed bench for kbd_matrix_scanner with a simple key-matrix model.
module tb_kbd_matrix_scanner;
   import kbd_pkg::*;

   localparam int unsigned ROWS = 9;
   localparam int unsigned COLS = 10;
   localparam int unsigned NK   = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [COLS-1:0] kbd_col;
   logic [ROWS-1:0] kbd_row;
   logic            evt_valid;
   logic            evt_ready;
   logic [8:0]      evt_data;
   logic [NK-1:0]   keys_state;
   logic            any_key;
   logic            scan_done;
   logic            fifo_overflow;
   logic            clear_overflow;
   logic            ghost;

   logic [NK-1:0]   tb_keys;
   int              n_checks = 0;
   int              n_errors = 0;

   always #5 clk = ~clk;

   // Closed key connects its driven column onto its row
   always_comb begin
      for (int r = 0; r < ROWS; r++) kbd_row[r] = |(tb_keys[r*COLS +: COLS] & kbd_col);
   end

   kbd_matrix_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_SCANS (2),
      .SCAN_GAP       (16),
      .FIFO_DEPTH     (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .kbd_col        (kbd_col),
      .kbd_row        (kbd_row),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_data       (evt_data),
      .keys_state     (keys_state),
      .any_key        (any_key),
      .scan_done      (scan_done),
      .fifo_overflow  (fifo_overflow),
      .clear_overflow (clear_overflow),
      .ghost          (ghost)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ev(input logic p, input int r, input int c);
      kbd_evt_t e;
      e.pressed = p;
      e.row     = 4'(r);
      e.col     = 4'(c);
      return e;
   endfunction

   function automatic int kb(input int r, input int c);
      return r * COLS + c;
   endfunction

   // Bounded wait for the next scan_done pulse
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 400);
      chk(tag, scan_done, 1'b1);
   endtask

   task automatic scans(input int k);
      for (int i = 0; i < k; i++) wait_done("scan_done_wait");
   endtask

   // Check head event then pop it
   task automatic pop_chk(input string tag, input logic [8:0] exp);
      chk({tag, "_valid"}, evt_valid, 1'b1);
      chk(tag, evt_data, exp);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   initial begin
      int n;
      int seen;
      int kr [10];
      int kc [10];
      logic [NK-1:0] mask;

      rst = 1'b1; enable = 1'b0; evt_ready = 1'b0; clear_overflow = 1'b0; tb_keys = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_kbd_col", kbd_col, '0);
      chk("rst_evt_valid", evt_valid, 1'b0);
      chk("rst_keys_state", keys_state, '0);
      chk("rst_any_key", any_key, 1'b0);
      chk("rst_scan_done", scan_done, 1'b0);
      chk("rst_overflow", fifo_overflow, 1'b0);
      chk("rst_ghost", ghost, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_kbd_col", kbd_col, '0);

      // Column walk: 5 cycles driven, 9 cycles dark per column
      enable = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("col_walk_on", kbd_col, COLS'(1) << c);
         end
         for (int k = 0; k < ROWS; k++) begin
            @(negedge clk);
            chk("col_walk_off", kbd_col, '0);
         end
      end
      @(negedge clk);
      chk("first_scan_done", scan_done, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 400);
      chk("scan_period", 32'(n), 32'd156);
      chk("no_key_no_evt", evt_valid, 1'b0);

      // Single key (3,2): press after two scans, release after two more
      tb_keys[kb(3,2)] = 1'b1;
      wait_done("s2a");
      chk("press_not_yet", evt_valid, 1'b0);
      chk("press_keys_not_yet", keys_state, '0);
      wait_done("s2b");
      mask = '0; mask[kb(3,2)] = 1'b1;
      chk("press_keys_state", keys_state, mask);
      chk("press_any_key", any_key, 1'b1);
      pop_chk("press_3_2", ev(1'b1, 3, 2));
      chk("press_single", evt_valid, 1'b0);
      tb_keys = '0;
      scans(2);
      pop_chk("release_3_2", ev(1'b0, 3, 2));
      chk("release_keys_state", keys_state, '0);
      chk("release_any_key", any_key, 1'b0);

      // Bounce: present, absent, present, present
      wait_done("s3_sync");
      tb_keys[kb(3,2)] = 1'b1;
      wait_done("s3_1");
      tb_keys = '0;
      wait_done("s3_2");
      chk("bounce_scan2", evt_valid, 1'b0);
      tb_keys[kb(3,2)] = 1'b1;
      wait_done("s3_3");
      chk("bounce_scan3", evt_valid, 1'b0);
      wait_done("s3_4");
      pop_chk("bounce_press", ev(1'b1, 3, 2));
      chk("bounce_single", evt_valid, 1'b0);
      tb_keys = '0;
      scans(2);
      pop_chk("bounce_release", ev(1'b0, 3, 2));

      // Two keys in one row, then two keys in one column
      wait_done("s4_sync");
      tb_keys[kb(3,2)] = 1'b1; tb_keys[kb(3,4)] = 1'b1;
      scans(2);
      pop_chk("row_pair_first", ev(1'b1, 3, 2));
      pop_chk("row_pair_second", ev(1'b1, 3, 4));
      chk("row_pair_empty", evt_valid, 1'b0);
      tb_keys = '0;
      scans(2);
      pop_chk("row_pair_rel_first", ev(1'b0, 3, 2));
      pop_chk("row_pair_rel_second", ev(1'b0, 3, 4));
      tb_keys[kb(1,5)] = 1'b1; tb_keys[kb(6,5)] = 1'b1;
      scans(2);
      pop_chk("col_pair_first", ev(1'b1, 1, 5));
      pop_chk("col_pair_second", ev(1'b1, 6, 5));
      tb_keys = '0;
      scans(2);
      pop_chk("col_pair_rel_first", ev(1'b0, 1, 5));
      pop_chk("col_pair_rel_second", ev(1'b0, 6, 5));
      chk("col_pair_empty", evt_valid, 1'b0);

      // Ten presses with the consumer stalled: eight kept in order, overflow sticky
      wait_done("s5_sync");
      kr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
      kc = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 9};
      mask = '0;
      for (int i = 0; i < 10; i++) begin
         tb_keys[kb(kr[i], kc[i])] = 1'b1;
         mask[kb(kr[i], kc[i])] = 1'b1;
      end
      scans(2);
      chk("ovf_set", fifo_overflow, 1'b1);
      chk("ovf_keys_state", keys_state, mask);
      chk("ovf_any_key", any_key, 1'b1);
      for (int i = 0; i < 8; i++) pop_chk("ovf_evt", ev(1'b1, kr[i], kc[i]));
      chk("ovf_drained", evt_valid, 1'b0);
      chk("ovf_still_set", fifo_overflow, 1'b1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk("ovf_cleared", fifo_overflow, 1'b0);
      evt_ready = 1'b1;
      tb_keys = '0;
      scans(2);
      evt_ready = 1'b0;
      @(negedge clk);
      chk("ovf_rel_keys", keys_state, '0);
      chk("ovf_rel_empty", evt_valid, 1'b0);
      chk("ovf_rel_no_drop", fifo_overflow, 1'b0);

      // enable dropped mid-scan: scan finishes, then the scanner idles
      wait_done("s6_sync");
      repeat (20) @(negedge clk);
      enable = 1'b0;
      wait_done("dis_scan_completes");
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (scan_done) seen++;
      end
      chk("dis_no_new_scan", 32'(seen), 32'd0);
      chk("dis_idle_col", kbd_col, '0);
      enable = 1'b1;

`ifdef KBD_GHOST_DETECT_EN
      // Ghost: three corners clean, fourth corner forms a rectangle
      wait_done("s7_sync");
      tb_keys[kb(1,2)] = 1'b1; tb_keys[kb(1,4)] = 1'b1; tb_keys[kb(3,2)] = 1'b1;
      scans(2);
      @(negedge clk);
      chk("ghost_three", ghost, 1'b0);
      tb_keys[kb(3,4)] = 1'b1;
      scans(2);
      @(negedge clk);
      chk("ghost_four", ghost, 1'b1);
`endif

      // Reset mid-scan clears everything without release events
      wait_done("s8_sync");
      tb_keys[kb(2,2)] = 1'b1; tb_keys[kb(5,7)] = 1'b1;
      scans(2);
      chk("pre_rst_keys", keys_state, tb_keys);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_kbd_col", kbd_col, '0);
      chk("mid_rst_evt_valid", evt_valid, 1'b0);
      chk("mid_rst_keys", keys_state, '0);
      chk("mid_rst_any_key", any_key, 1'b0);
      chk("mid_rst_scan_done", scan_done, 1'b0);
      chk("mid_rst_overflow", fifo_overflow, 1'b0);
      chk("mid_rst_ghost", ghost, 1'b0);
      tb_keys = '0;
      rst = 1'b0;
      scans(2);
      chk("post_rst_no_release", evt_valid, 1'b0);
      chk("post_rst_keys", keys_state, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
